instruction_store: RTL and testbench

- Program memory and loader that supplies the `instruction` word consumed by the control unit and the multiprocessor array.
- Returns the instruction addressed by the control unit's `program_counter`.
- Before execution, a host streams the program in over a valid/ready word interface.
- Holds the processor core in reset while loading, then releases it to run.

---
 rtl/instruction_store_pkg.sv | 14 +
 rtl/instruction_store_if.sv | 22 ++
 rtl/instruction_store_ram.sv | 25 ++
 rtl/instruction_store.sv | 103 ++++++++++
 tb/tb_instruction_store.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/instruction_store_pkg.sv
// rtl/instruction_store_pkg.sv - ISA constants and loader state encoding shared by the instruction store.
package instruction_store_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int PC_WIDTH    = 12;
  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } store_state_t;

endpackage

// File: rtl/instruction_store_if.sv
// rtl/instruction_store_if.sv - host program-load word stream (valid/ready with last and restart pulse).
interface instruction_store_if #(
  parameter int DW = 16
);

  logic          load_start;
  logic          load_valid;
  logic          load_ready;
  logic [DW-1:0] load_data;
  logic          load_last;

  modport master (
    output load_start, load_valid, load_data, load_last,
    input  load_ready
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    output load_ready
  );

endinterface

// File: rtl/instruction_store_ram.sv
// rtl/instruction_store_ram.sv - program RAM: one synchronous write port, one asynchronous read port.
module instruction_ram #(
  parameter int AW    = 12,
  parameter int DW    = 16,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_store.sv
// rtl/instruction_store.sv - program loader and fetch port; holds the core in reset until a complete load.
module instruction_store #(
  parameter int ADDR_WIDTH  = instruction_store_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = instruction_store_pkg::INSTR_WIDTH,
  parameter int DEPTH       = 2 ** ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  instruction_store_if.slave     load_if,
  input  logic [ADDR_WIDTH-1:0]  program_counter,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   core_rst,
  output logic                   running,
  output logic [ADDR_WIDTH:0]    program_length,
  output logic                   truncated
);

  import instruction_store_pkg::*;

  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_START = ST_START;
  localparam logic [1:0] S_RUN   = ST_RUN;

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  count_q, count_d;
  logic [ADDR_WIDTH:0]    len_q, len_d;
  logic                   trunc_q, trunc_d;
  logic                   xfer;
  logic                   at_end;
  logic [INSTR_WIDTH-1:0] rdata;

  assign load_if.load_ready = rst && (state_q == S_LOAD);
  // A word offered together with load_start belongs to the aborted load.
  assign xfer   = load_if.load_valid && load_if.load_ready && !load_if.load_start;
  assign at_end = (count_q == ADDR_WIDTH'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    if (load_if.load_start) begin
      state_d = S_LOAD;
      count_d = '0;
      len_d   = '0;
      trunc_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (xfer) begin
            count_d = count_q + 1'b1;
            len_d   = {1'b0, count_q} + 1'b1;
            if (load_if.load_last || at_end) begin
              state_d = S_START;
            end
            if (at_end && !load_if.load_last) begin
              trunc_d = 1'b1;
            end
          end
        end
        S_START: state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_LOAD;
      count_q <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
    end
  end

  instruction_ram #(
    .AW    (ADDR_WIDTH),
    .DW    (INSTR_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (xfer),
    .waddr_i (count_q),
    .wdata_i (load_if.load_data),
    .raddr_i (program_counter),
    .rdata_o (rdata)
  );

  assign running        = (state_q == S_START) || (state_q == S_RUN);
  assign core_rst       = (state_q == S_RUN);
  assign program_length = len_q;
  assign truncated      = trunc_q;

  // Past the program end the core sees NOPs, never leftovers of an older program.
  assign instruction = (running && ({1'b0, program_counter} < len_q)) ? rdata : INSTR_NOP;

endmodule

// File: tb/tb_instruction_store.sv
// tb/tb_instruction_store.sv - scoreboard bench for instruction_store with a random-stimulus reference model.
module tb_instruction_store;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] pc = '0;
  logic [15:0] instr;
  logic        core_rst, running, trunc;
  logic [12:0] plen;

  instruction_store_if #(.DW(16)) lif();

  instruction_store dut (
    .clk             (clk),
    .rst             (rst),
    .load_if         (lif),
    .program_counter (pc),
    .instruction     (instr),
    .core_rst        (core_rst),
    .running         (running),
    .program_length  (plen),
    .truncated       (trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [15:0] instr;
    bit          ready;
    bit          running;
    bit          core_rst;
    bit          trunc;
    logic [12:0] len;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: phase 0 = loading, 1 = start cycle, 2 = running.
  logic [15:0] m_mem [4096];
  int          m_phase = 0;
  int          m_count = 0;
  int          m_len   = 0;
  bit          m_trunc = 1'b0;

  task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.chk) begin
        cmp("load_ready", 32'(lif.load_ready), 32'(e.ready));
        cmp("running", 32'(running), 32'(e.running));
        cmp("core_rst", 32'(core_rst), 32'(e.core_rst));
        cmp("program_length", 32'(plen), 32'(e.len));
        cmp("truncated", 32'(trunc), 32'(e.trunc));
        cmp("instruction", 32'(instr), 32'(e.instr));
      end
    end
  end

  task automatic cyc(bit r, bit st, bit v, logic [15:0] d, bit l, logic [11:0] p, bit chk = 1'b1);
    exp_t e;
    rst = r;
    lif.load_start = st;
    lif.load_valid = v;
    lif.load_data  = d;
    lif.load_last  = l;
    pc = p;
    e.chk      = chk;
    e.ready    = (m_phase == 0) && r;
    e.running  = (m_phase != 0);
    e.core_rst = (m_phase == 2);
    e.trunc    = m_trunc;
    e.len      = 13'(m_len);
    e.instr    = (m_phase != 0 && int'(p) < m_len) ? m_mem[p] : 16'h0000;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (!r || st) begin
      m_phase = 0;
      m_count = 0;
      m_len   = 0;
      m_trunc = 1'b0;
    end else if (m_phase == 0) begin
      if (v) begin
        m_mem[m_count] = d;
        m_len = m_count + 1;
        if (l || m_count == 4095) begin
          m_phase = 1;
          if (!l) m_trunc = 1'b1;
        end
        m_count++;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end
  endtask

  function automatic logic [11:0] rpc();
    if (m_len > 0 && $urandom_range(0, 1) == 1) return 12'($urandom_range(0, m_len));
    return 12'($urandom);
  endfunction

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 16'($urandom), 1'($urandom), rpc());
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'($urandom), 16'($urandom), 1'($urandom), rpc());
  endtask

  task automatic send(logic [15:0] d, bit l);
    cyc(1'b1, 1'b0, 1'b1, d, l, rpc());
  endtask

  task automatic restart();
    cyc(1'b1, 1'b1, 1'($urandom), 16'($urandom), 1'($urandom), rpc());
  endtask

  task automatic load_prog(int n, int gap_pct, bit with_last);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) idle(1);
      send(16'($urandom), with_last && (i == n - 1));
    end
  endtask

  initial begin
    lif.load_start = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_last  = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 12'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 12'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h5555, 1'b1, 12'd0);
    idle(2);

    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 16'h4444, 1'b1, 12'd1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 12'd1);
    cyc(1'b1, 1'b0, 1'b1, 16'h4444, 1'b0, 12'd3);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 12'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 12'd2);
    run(10);

    restart();
    idle(1);
    send(16'hAAAA, 1'b1);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 12'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 12'd1);

    restart();
    send(16'($urandom), 1'b0);
    idle(1);
    send(16'($urandom), 1'b0);
    idle(1);
    send(16'($urandom), 1'b1);
    idle(1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 12'(i));

    restart();
    send(16'($urandom), 1'b0);
    send(16'($urandom), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0, rpc());
    idle(3);
    load_prog(4, 30, 1'b1);
    run(8);

    restart();
    send(16'h1234, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b0, 12'd0);
    send(16'h5678, 1'b1);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 12'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 12'd1);

    for (int k = 0; k < 6; k++) begin
      restart();
      load_prog($urandom_range(1, 40), 30, 1'b1);
      run(20);
    end

    restart();
    load_prog(4096, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'h0, 1'b1, 12'd4095);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 12'd4095);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 12'd0);
    run(20);

    restart();
    idle(2);

    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
